// File: rtl/fast_ram_16k_pkg.sv
// Shared memory-subsystem constants and types.
// Provides word/address widths, bank geometry and the word typedef used by
// the 16K data RAM, its banks and its bus interface.
package memory_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 14;
    localparam int BANK_ADDR_W = 12;
    localparam int NUM_BANKS   = 4;
    localparam int BANK_SEL_W  = ADDR_W - BANK_ADDR_W;

    typedef logic [DATA_W-1:0]      word_t;
    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [BANK_ADDR_W-1:0] bank_addr_t;
    typedef logic [BANK_SEL_W-1:0]  bank_sel_t;

endpackage : memory_pkg

// File: rtl/fast_ram_16k_if.sv
// Bus interface of the 16K data RAM.
// Signals:
//   out     - read data, the word at address (driven by the RAM)
//   in      - write data
//   address - word address shared by read and write
//   load    - write enable, sampled on the rising clock edge
// Modports: master drives in/address/load, slave drives out.
interface fast_ram_16k_if
    import memory_pkg::*;
#(
    parameter int DATA_W = memory_pkg::DATA_W,
    parameter int ADDR_W = memory_pkg::ADDR_W
);

    logic [DATA_W-1:0] out;
    logic [DATA_W-1:0] in;
    logic [ADDR_W-1:0] address;
    logic              load;

    modport master (
        input  out,
        output in,
        output address,
        output load
    );

    modport slave (
        output out,
        input  in,
        input  address,
        input  load
    );

endinterface : fast_ram_16k_if

// File: rtl/fast_ram_16k_ram4k.sv
// fast_ram4k: 4096 x 16 memory bank.
// Combinational read, synchronous write on the rising edge of clk.
// Ports:
//   clk   - system clock
//   rst_n - active-low reset; blocks writes and forces rdata to 0 while low
//   we    - write enable for this bank
//   addr  - word offset within the bank
//   wdata - write data
//   rdata - read data (mem[addr], or 0 while in reset)
// Contents power up as zero and are never cleared by reset.
module fast_ram4k
    import memory_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  bank_addr_t addr,
    input  word_t      wdata,
    output word_t      rdata
);

    localparam int DEPTH = 1 << BANK_ADDR_W;

    word_t mem_r [DEPTH] = '{default: 16'h0000};

    // Write port: rst_n is sampled at the edge so a write coinciding with
    // reset release only lands if reset is already high at that edge.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read port: asynchronous, forced to zero while reset is asserted.
    always_comb begin
        rdata = 16'h0000;
        if (rst_n) begin
            rdata = mem_r[addr];
        end else begin
            rdata = 16'h0000;
        end
    end

endmodule : fast_ram4k

// File: rtl/fast_ram_16k.sv
// fast_ram_16k: 16K x 16 main data RAM built from four 4K banks.
// Ports:
//   clk   - system clock, writes on the rising edge
//   rst_n - asynchronous active-low reset (out forced to 0, writes blocked)
//   bus   - slave side of fast_ram_16k_if (out, in, address, load)
// address[13:12] selects the bank, address[11:0] is the offset in the bank.
// Only the selected bank sees load; out is muxed from the selected bank.
module fast_ram_16k
    import memory_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fast_ram_16k_if.slave  bus
);

    bank_sel_t  bank_sel_s;
    bank_addr_t bank_addr_s;
    logic       bank_we_s [NUM_BANKS];
    word_t      bank_rdata_s [NUM_BANKS];

    assign bank_sel_s  = bus.address[ADDR_W-1:BANK_ADDR_W];
    assign bank_addr_s = bus.address[BANK_ADDR_W-1:0];

    // Write-enable gating: route load only to the addressed bank.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we_s[b] = 1'b0;
            if (bus.load && (bank_sel_s == bank_sel_t'(b))) begin
                bank_we_s[b] = 1'b1;
            end else begin
                bank_we_s[b] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        fast_ram4k u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we_s[g]),
            .addr  (bank_addr_s),
            .wdata (bus.in),
            .rdata (bank_rdata_s[g])
        );
    end

    // Output mux from the selected bank; banks already zero their data in reset.
    always_comb begin
        bus.out = 16'h0000;
        case (bank_sel_s)
            2'd0:    bus.out = bank_rdata_s[0];
            2'd1:    bus.out = bank_rdata_s[1];
            2'd2:    bus.out = bank_rdata_s[2];
            2'd3:    bus.out = bank_rdata_s[3];
            default: bus.out = 16'h0000;
        endcase
    end

endmodule : fast_ram_16k

// File: tb/tb_fast_ram_16k.sv
// Self-checking bench for fast_ram_16k. A flat 16K-entry array serves as the
// reference memory; out is expected to equal model[address] outside reset
// and 0 during reset.
module tb_fast_ram_16k;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    logic [15:0] model [16384];

    fast_ram_16k_if bus ();

    fast_ram_16k dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs change on the falling edge, the model is
    // updated at the rising edge, then the task returns 1 time unit later.
    task automatic drive_cycle(input logic [13:0] a, input logic [15:0] d, input logic l);
        @(negedge clk);
        bus.address = a;
        bus.in      = d;
        bus.load    = l;
        @(posedge clk);
        if (l && rst_n) model[a] = d;
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.address = 14'h0800;
        bus.in      = 16'hFFFF;
        bus.load    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out !== 16'h0000) begin
                bad++;
                $display("FAIL reset_out edge%0d: got %h want 0000", i, bus.out);
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
        rst_n    = 1'b1;
        #1;
        total++;
        if (bus.out !== model[14'h0800]) begin
            bad++;
            $display("FAIL reset_suppressed_write: got %h want %h", bus.out, model[14'h0800]);
        end
    endtask

    task automatic test_write_read();
        logic [13:0] addrs [5];
        logic [15:0] datas [5];
        addrs = '{14'h0800, 14'h1000, 14'h0801, 14'h1801, 14'h2001};
        datas = '{16'h0001, 16'h0003, 16'h001F, 16'h007F, 16'h00FF};
        for (int i = 0; i < 5; i++) drive_cycle(addrs[i], datas[i], 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(addrs[i], 16'h0000, 1'b0);
            total++;
            if (bus.out !== datas[i]) begin
                bad++;
                $display("FAIL write_read @%h: got %h want %h", addrs[i], bus.out, datas[i]);
            end
        end
    endtask

    task automatic test_load_gating();
        logic [13:0] addrs [3];
        logic [15:0] datas [3];
        addrs = '{14'h1800, 14'h0001, 14'h1001};
        datas = '{16'h0007, 16'h000F, 16'h003F};
        for (int i = 0; i < 3; i++) drive_cycle(addrs[i], datas[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.address = addrs[i];
            #1;
            total++;
            if (bus.out !== 16'h0000) begin
                bad++;
                $display("FAIL load_gating @%h: got %h want 0000", addrs[i], bus.out);
            end
        end
    endtask

    task automatic test_bank_isolation();
        logic [13:0] addrs [4];
        logic [15:0] exp_v [4];
        drive_cycle(14'h0000, 16'hAAAA, 1'b1);
        drive_cycle(14'h3000, 16'h5555, 1'b1);
        addrs = '{14'h1000, 14'h2000, 14'h0000, 14'h3000};
        exp_v = '{16'h0003, 16'h0000, 16'hAAAA, 16'h5555};
        for (int i = 0; i < 4; i++) begin
            bus.address = addrs[i];
            #1;
            total++;
            if (bus.out !== exp_v[i]) begin
                bad++;
                $display("FAIL bank_isolation @%h: got %h want %h", addrs[i], bus.out, exp_v[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [13:0] addrs [2];
        logic [15:0] datas [2];
        logic [15:0] old_v;
        addrs = '{14'h3FFF, 14'h0000};
        datas = '{16'h1234, 16'h4321};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.address = addrs[i];
            bus.in      = datas[i];
            bus.load    = 1'b1;
            old_v       = model[addrs[i]];
            #1;
            total++;
            if (bus.out !== old_v) begin
                bad++;
                $display("FAIL same_cycle_before @%h: got %h want %h", addrs[i], bus.out, old_v);
            end
            @(posedge clk);
            model[addrs[i]] = datas[i];
            #1;
            bus.load = 1'b0;
            total++;
            if (bus.out !== datas[i]) begin
                bad++;
                $display("FAIL same_cycle_after @%h: got %h want %h", addrs[i], bus.out, datas[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // Pulse reset between edges: out must drop with no clock edge.
        @(negedge clk);
        bus.address = 14'h0800;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_out: got %h want 0000", bus.out);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.out !== 16'h0001) begin
            bad++;
            $display("FAIL async_reset_retain: got %h want 0001", bus.out);
        end
        // A write attempted across an edge while reset is low must be dropped.
        @(negedge clk);
        bus.address = 14'h0801;
        bus.in      = 16'hBEEF;
        bus.load    = 1'b1;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        rst_n    = 1'b1;
        #1;
        total++;
        if (bus.out !== 16'h001F) begin
            bad++;
            $display("FAIL reset_blocks_write: got %h want 001F", bus.out);
        end
    endtask

    task automatic test_random();
        logic [13:0] a;
        logic [15:0] d;
        logic        l;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 14'h0000;
                1:       a = 14'h3FFF;
                2:       a = 14'(($urandom_range(0, 3) << 12) | $urandom_range(0, 3));
                default: a = 14'($urandom_range(0, 16383));
            endcase
            d = 16'($urandom());
            l = 1'($urandom_range(0, 1));
            drive_cycle(a, d, l);
            total++;
            if (bus.out !== model[a]) begin
                bad++;
                $display("FAIL random_rw #%0d @%h: got %h want %h", i, a, bus.out, model[a]);
            end
            // Combinational read of another address, no clock involved.
            a = 14'($urandom_range(0, 16383));
            if (i % 2 == 0) a = {a[13:12], 12'(i % 4)};
            bus.address = a;
            #1;
            total++;
            if (bus.out !== model[a]) begin
                bad++;
                $display("FAIL random_read #%0d @%h: got %h want %h", i, a, bus.out, model[a]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
        bus.address = 14'h0000;
        bus.in      = 16'h0000;
        bus.load    = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_write_read();
        test_load_gating();
        test_bank_isolation();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fast_ram_16k
